// File: rtl/entrada_operandos.sv
// Operand-entry controller: synchronizes the switches and the enter button, debounces the
// button, and captures A, B and the operation select one value per debounced press.
module entrada_operandos #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       op_sel,
    input  logic       btn,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic       selector,
    output logic       valid,
    output logic [1:0] fase
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SHOW   = 2'd2
    } state_t;

    logic [3:0] raw_in;
    logic [3:0] sync_in;
    logic [1:0] sw_s;
    logic       op_s;
    logic       btn_s;

    assign raw_in = {btn, op_sel, sw};

    // Every asynchronous input bit gets its own two-flop synchronizer.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic s1_q;
            logic s2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                end else begin
                    s1_q <= raw_in[gi];
                    s2_q <= s1_q;
                end
            end
            assign sync_in[gi] = s2_q;
        end
    endgenerate

    assign sw_s  = sync_in[1:0];
    assign op_s  = sync_in[2];
    assign btn_s = sync_in[3];

    logic             db_q, db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (btn_s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = btn_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Only the debounced rising edge acts; release is ignored.
    assign press = db_q & ~db_dly_q;

    state_t     state_q, state_d;
    logic [1:0] a_q, a_d;
    logic [1:0] b_q, b_d;
    logic       sel_q, sel_d;
    logic       valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    a_d     = sw_s;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    b_d     = sw_s;
                    sel_d   = op_s;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    a_d     = 2'd0;
                    b_d     = 2'd0;
                    sel_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = WAIT_A;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_A;
            a_q     <= 2'd0;
            b_q     <= 2'd0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign selector = sel_q;
    assign valid    = valid_q;
    assign fase     = state_q;

endmodule

// File: tb/tb_entrada_operandos.sv
// Bench for entrada_operandos: table-driven operand sequences with a scoreboard queue,
// plus hand-written bounce, switch-independence and reset-during-press sequences.
module tb_entrada_operandos;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       op_sel;
    logic       btn;
    logic [1:0] A;
    logic [1:0] B;
    logic       selector;
    logic       valid;
    logic [1:0] fase;

    int checks   = 0;
    int failures = 0;

    entrada_operandos #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .op_sel   (op_sel),
        .btn      (btn),
        .A        (A),
        .B        (B),
        .selector (selector),
        .valid    (valid),
        .fase     (fase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] fase;
        logic       valid;
        logic [1:0] a;
        logic [1:0] b;
        logic       sel;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [1:0] sw_a;
        logic [1:0] sw_b;
        logic       op;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [1:0] ef, input logic ev,
                           input logic [1:0] ea, input logic [1:0] eb, input logic es);
        chk({nm, "_fase"}, fase, ef);
        chk({nm, "_valid"}, valid, ev);
        chk({nm, "_A"}, A, ea);
        chk({nm, "_B"}, B, eb);
        chk({nm, "_sel"}, selector, es);
    endtask

    // Holds btn for 20 cycles; expects exactly one state change, 6 edges after e0.
    task automatic do_press(input string nm, input logic [1:0] swv, input logic opv,
                            input logic [1:0] ef, input logic ev,
                            input logic [1:0] ea, input logic [1:0] eb, input logic es);
        exp_t       e;
        logic [1:0] prev;
        int         k;
        bit         found;
        sw     = swv;
        op_sel = opv;
        repeat (3) @(negedge clk);
        e.name = nm; e.fase = ef; e.valid = ev; e.a = ea; e.b = eb; e.sel = es;
        sb_q.push_back(e);
        prev  = fase;
        btn   = 1'b1;
        found = 0;
        k     = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            k++;
            if (fase != prev) found = 1;
        end
        e = sb_q.pop_front();
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_transition expected=transition", e.name);
        end else begin
            chk({e.name, "_latency"}, k - 1, 6);
            chk_all(e.name, e.fase, e.valid, e.a, e.b, e.sel);
            $display("press %s: fase=%0d valid=%0d A=%0d B=%0d sel=%0d edges=%0d",
                     e.name, fase, valid, A, B, selector, k - 1);
        end
        repeat (20 - k) @(negedge clk);
        chk({e.name, "_held_once"}, fase, e.fase);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{sw_a: 2'd3, sw_b: 2'd2, op: 1'b0};
        vecs[1] = '{sw_a: 2'd3, sw_b: 2'd3, op: 1'b1};
        vecs[2] = '{sw_a: 2'd1, sw_b: 2'd2, op: 1'b1};
        vecs[3] = '{sw_a: 2'd0, sw_b: 2'd3, op: 1'b0};
        vecs[4] = '{sw_a: 2'd2, sw_b: 2'd1, op: 1'b1};

        rst = 1'b1; sw = 2'd0; op_sel = 1'b0; btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all("reset", 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        $display("reset: fase=%0d valid=%0d A=%0d B=%0d sel=%0d", fase, valid, A, B, selector);

        for (int i = 0; i < 5; i++) begin
            do_press($sformatf("v%0d_a", i), vecs[i].sw_a, ~vecs[i].op,
                     2'd1, 1'b0, vecs[i].sw_a, 2'd0, 1'b0);
            do_press($sformatf("v%0d_b", i), vecs[i].sw_b, vecs[i].op,
                     2'd2, 1'b1, vecs[i].sw_a, vecs[i].sw_b, vecs[i].op);
            do_press($sformatf("v%0d_clr", i), 2'd3, 1'b1,
                     2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        end

        // Bounce: 3 cycles high, 1 low, five times; must never register.
        sw = 2'd3;
        for (int r = 0; r < 5; r++) begin
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce_fase", fase, 0);
        chk("bounce_A", A, 0);
        $display("bounce: fase=%0d A=%0d", fase, A);
        do_press("hold_a", 2'd3, 1'b0, 2'd1, 1'b0, 2'd3, 2'd0, 1'b0);

        // Switches moving every cycle in WAIT_B without a press change nothing.
        for (int c = 0; c < 16; c++) begin
            sw     = 2'(c);
            op_sel = c[0];
            @(negedge clk);
            chk("swind_A", A, 3);
            chk("swind_B", B, 0);
            chk("swind_sel", selector, 0);
            chk("swind_fase", fase, 1);
        end
        $display("switch_toggle: fase=%0d A=%0d B=%0d sel=%0d", fase, A, B, selector);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all("rst_mid", 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        do_press("pre_rst_a", 2'd2, 1'b0, 2'd1, 1'b0, 2'd2, 2'd0, 1'b0);

        // Reset lands on the same edge the press would capture B.
        sw = 2'd1; op_sel = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_fase", fase, 1);
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_all("rst_press", 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (12) @(negedge clk);
        chk_all("rst_no_capture", 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        $display("reset_with_press: fase=%0d valid=%0d A=%0d B=%0d", fase, valid, A, B);
        do_press("post_rst_a", 2'd1, 1'b0, 2'd1, 1'b0, 2'd1, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/entrada_operandos.md
# entrada_operandos

Operand-entry controller that sits directly upstream of the 2-bit add/multiply stage. It captures operand A, operand B and the operation select from slide switches, one value per press of a debounced push button. It presents them as stable registered outputs together with a `valid` flag. The arithmetic stage and the BCD 7-segment decoder downstream stay purely combinational; this block supplies all of the design's sequential behaviour.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized button level must differ from the current debounced level before the debounced level changes; legal range 2..65535.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  2  operand value switches, asynchronous to `clk`.
- `op_sel`  in  1  operation switch: 0 = add, 1 = multiply. Asynchronous.
- `btn`  in  1  raw "enter" push button, active-high, bouncy and asynchronous.
- `A`  out  2  registered operand A.
- `B`  out  2  registered operand B.
- `selector`  out  1  registered operation select.
- `valid`  out  1  high while A/B/selector form a complete, stable operand set.
- `fase`  out  2  current FSM state code: 0 WAIT_A, 1 WAIT_B, 2 SHOW.

## Operation
**Input conditioning**
- `btn` passes through a 2-flop synchronizer to produce `s2`.
- `sw` and `op_sel` are also double-flopped before capture.

**Debouncer**
- Holds a debounced level `db` and a counter `cnt`.
- If `s2 == db`, `cnt` is set to 0.
- If `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`, `db` is set to `s2` and `cnt` is set to 0.
- Otherwise `cnt` increments.
- The counter width covers `DEBOUNCE_CYCLES-1`.

**Press detection**
- `press = db & ~db_q`, where `db_q` is `db` delayed by one cycle.
- This gives exactly one pulse per debounced rising edge.
- Releasing the button produces no action.

**FSM**
- WAIT_A: on `press`, A <= synchronized `sw`; go to WAIT_B.
- WAIT_B: on `press`, B <= synchronized `sw` and selector <= synchronized `op_sel`; `valid` <= 1; go to SHOW.
- SHOW: on `press`, A, B and selector <= 0; `valid` <= 0; go to WAIT_A.
- Without `press`, every register holds its value.
- Switch movement between presses has no effect.
- Unused state code 3 returns to WAIT_A with `valid` = 0 on the next edge.

**Output rules**
- A, B and selector change only on a capture edge, on the SHOW clear, or on reset.
- The downstream result (A+B or A*B, max 9) is therefore constant while `valid` = 1.

## Timing
**Reset**
- `rst` = 1 at a rising edge forces the following to 0: A, B, selector, `valid`, `fase` (WAIT_A), synchronizer flops, `db`, `db_q` and `cnt`.
- Reset has priority over every other event, including a `press` in the same cycle.
- Reset mid-sequence discards any partial entry.

**Press latency**
- Let e0 be the first edge that samples `btn` = 1, with the level held stable.
- `s2` = 1 after e1.
- `db` rises at edge e0 + DEBOUNCE_CYCLES + 1.
- `press` is high for exactly one cycle.
- The capture register and `fase` update at edge e0 + DEBOUNCE_CYCLES + 2. With the default, that is 6 edges after e0.

**Bounce and hold**
- A high level on `s2` shorter than DEBOUNCE_CYCLES consecutive cycles never changes `db` and causes no action.
- A held button yields exactly one `press`.
- A new `press` requires a debounced release: `s2` low for DEBOUNCE_CYCLES consecutive cycles.

**Outputs**
- `fase` and `valid` are registered and change in the same edge as the state transition.

## Test plan
- **Add:** reset, sw=3, press; sw=2, op_sel=0, press → fase=2, valid=1, A=3, B=2, selector=0 (downstream sum 5).
- **Multiply:** sw=3, press; sw=3, op_sel=1, press → A=3, B=3, selector=1, valid=1 (product 9); a third press → all outputs 0, fase=0.
- **Bounce:** with DEBOUNCE_CYCLES=4, drive `btn` high for 3 cycles, low for 1, repeated 5 times → fase stays 0 and A unchanged. Then hold `btn` high for 20 cycles → exactly one capture, at edge e0+6.
- **Switch independence:** toggle `sw`/`op_sel` every cycle while in WAIT_B with no press → A, B and selector stable.
- **Reset:** assert `rst` for 1 cycle in WAIT_B (A=2), coincident with a `press` → all outputs 0, fase=0, no capture. The next stable press loads A.
